multicycle_controller: RTL
==========================

# multicycle_controller

Multi-cycle sequencing FSM for the RV32I integer datapath: ALU, register file, sign extender, and a shared single-port instruction/data memory. It steps each instruction through fetch, decode, execute, memory and writeback. For each step it drives the datapath enables, the mux selects and the memory request handshake. It replaces the single-cycle `control_unit` decode so the datapath can share one memory port and tolerate wait states.

## Interface
- `MEM_TIMEOUT`, default 16: maximum wait cycles per memory request; 0 disables the timeout.
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `run`  in  1  level; allows the controller to leave IDLE and start new instructions.
- `instr`  in  32  instruction register contents (valid from DECODE on).
- `mem_ready`  in  1  memory completion; sampled only while `mem_req`=1.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  write qualifier for `mem_req`.
- `adr_src`  out  1  memory address select: 0=PC, 1=ALU result register.
- `ir_write`  out  1  load the instruction register.
- `pc_write`  out  1  load PC with PC+4.
- `reg_write`  out  1  register file write enable.
- `alu_src_b`  out  1  ALU operand B select: 0=rs2, 1=imm_ext.
- `result_src`  out  1  writeback select: 0=ALU result register, 1=memory read data.
- `alu_op`  out  4  `alu_op_t` code.
- `sign_extend_type`  out  3  `sign_extend_t` code.
- `busy`  out  1  high in every state except IDLE and HALT.
- `halted`  out  1  high in HALT.
- `fault`  out  2  0=none, 1=illegal opcode, 2=memory timeout.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, ALU_WB, MEM_READ, MEM_WB, MEM_WRITE, HALT.
- Outputs are Moore, decoded from state and `instr`, except `ir_write`/`pc_write`/`reg_write` in wait states, which are qualified by `mem_ready`.
- IDLE: all outputs 0. Moves to FETCH when `run`=1.
- FETCH: `mem_req`=1, `adr_src`=0.
  - On `mem_ready`: `ir_write`=1 and `pc_write`=1 in that cycle, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: one cycle. Classify the opcode.
  - Opcodes 0110011, 0010011, 0110111, 0000011, 0100011 go to EXECUTE.
  - Any other opcode goes to HALT with `fault`=1.
- EXECUTE, per opcode:
  - R-type: funct3/funct7 decode to `alu_op`; `alu_src_b`=0.
  - I-type: `alu_src_b`=1; SLLI/SRLI/SRAI use SLLI extend, others use ADDI extend.
  - LUI: BPASS with LUI extend.
  - LOAD: ADD with ADDI extend.
  - STORE: ADD with SW extend.
  - Next state: R-type/I-type/LUI go to ALU_WB, LOAD to MEM_READ, STORE to MEM_WRITE.
  - Undefined funct7 combinations decode as ADD. No latch inference: every output gets a default.
- ALU_WB: `reg_write`=1, `result_src`=0. Then FETCH if `run`=1, else IDLE.
- MEM_READ: `mem_req`=1, `adr_src`=1. On `mem_ready` go to MEM_WB.
- MEM_WB: `reg_write`=1, `result_src`=1. Then FETCH or IDLE, as for ALU_WB.
- MEM_WRITE: `mem_req`=1, `mem_we`=1, `adr_src`=1. On `mem_ready` go to FETCH or IDLE.
- HALT: absorbing state. All strobes 0; `fault` holds its value. Left only via `reset`.
- `run` deasserted mid-instruction: the current instruction completes, and the controller stops at the next fetch boundary.

## Timing
- Reset: state IDLE, wait counter 0, every output 0 (including `fault`). The reset is asynchronous, so outputs go to 0 immediately, regardless of `clk`.
- With zero-wait memory (`mem_ready` tied 1):
  - ALU/LUI instruction: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
- Each memory wait cycle adds 1 cycle.
- Handshake:
  - `mem_req`, `mem_we` and `adr_src` stay stable from assertion until the cycle `mem_ready`=1; that cycle is the transfer.
  - `mem_ready` while `mem_req`=0 is ignored.
- Wait counter:
  - Counts cycles with `mem_req`=1 and `mem_ready`=0.
  - Clears on every transfer and on every state change.
  - When it reaches `MEM_TIMEOUT`, the next state is HALT with `fault`=2.
  - `mem_ready` in the same cycle as the terminal count wins: the transfer completes.
- `pc_write` and `ir_write` each assert exactly once per instruction, in the same cycle.

## Configuration
- `MULTICYCLE_CONTROLLER_PERF_EN` defined:
  - Adds outputs `cycle_count` (32 bits, increments every cycle while `busy`).
  - Adds `instret_count` (32 bits, increments on the final cycle of each completed instruction).
  - Both counters wrap modulo 2^32 and reset to 0.
- Undefined: neither port nor counter exists, and the rest of the behaviour is identical.

## Structure
- Shared package `cpu_pkg` holds `alu_op_t` (ADD..BPASS, 4 bits), `sign_extend_t` (3 bits), `opcode_t`, and `ctrl_state_t`. The datapath and this controller import the same definitions.
- One sub-module, `mem_wait_timer`: the wait counter plus terminal-count compare, parameterised by `MEM_TIMEOUT`.

## Test plan
- `run`=1, `mem_ready`=1, `instr`=0x00500093 (addi x1,x0,5):
  - `mem_req`/`ir_write`/`pc_write` high in cycle 0.
  - EXECUTE in cycle 2 with `alu_op`=ADD, `alu_src_b`=1.
  - `reg_write`=1 in cycle 3; FETCH again in cycle 4.
- `instr`=0x0000A103 (lw x2,0(x1)), with `mem_ready` low for 3 cycles in MEM_READ:
  - `adr_src`=1 held stable throughout the wait.
  - MEM_WB with `result_src`=1 follows; total 8 cycles.
- `instr`=0x0020A223 (sw x2,4(x1)):
  - `mem_we`=1, `sign_extend_type`=SW in EXECUTE/MEM_WRITE.
  - `reg_write` never asserted.
- `instr`=0xFFFFFFFF: HALT after DECODE with `fault`=1; outputs stay 0 for 10 more cycles.
- `MEM_TIMEOUT`=4 and `mem_ready`=0 in FETCH: HALT with `fault`=2 after exactly 4 wait cycles.
- Assert `reset` low in MEM_READ: all outputs 0 the same cycle; IDLE after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared RV32I control encodings: ALU ops, immediate formats, opcodes and controller states.
// The datapath and the multicycle controller import these so both sides agree on every code.
package cpu_pkg;

   typedef enum logic [3:0] {
      ALU_ADD   = 4'd0,
      ALU_SUB   = 4'd1,
      ALU_SLL   = 4'd2,
      ALU_SLT   = 4'd3,
      ALU_SLTU  = 4'd4,
      ALU_XOR   = 4'd5,
      ALU_SRL   = 4'd6,
      ALU_SRA   = 4'd7,
      ALU_OR    = 4'd8,
      ALU_AND   = 4'd9,
      ALU_BPASS = 4'd10
   } alu_op_t;

   typedef enum logic [2:0] {
      EXT_ADDI = 3'd0,
      EXT_SLLI = 3'd1,
      EXT_SW   = 3'd2,
      EXT_LUI  = 3'd3
   } sign_extend_t;

   typedef enum logic [6:0] {
      OP_LOAD  = 7'b0000011,
      OP_IMM   = 7'b0010011,
      OP_STORE = 7'b0100011,
      OP_REG   = 7'b0110011,
      OP_LUI   = 7'b0110111
   } opcode_t;

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_FETCH     = 4'd1,
      S_DECODE    = 4'd2,
      S_EXECUTE   = 4'd3,
      S_ALU_WB    = 4'd4,
      S_MEM_READ  = 4'd5,
      S_MEM_WB    = 4'd6,
      S_MEM_WRITE = 4'd7,
      S_HALT      = 4'd8
   } ctrl_state_t;

   typedef enum logic [1:0] {
      FAULT_NONE    = 2'd0,
      FAULT_ILLEGAL = 2'd1,
      FAULT_TIMEOUT = 2'd2
   } fault_t;

   typedef struct packed {
      alu_op_t      op;
      sign_extend_t ext;
      logic         src_b;
   } alu_ctrl_t;

   function automatic logic opcode_legal(input logic [6:0] opc);
      return (opc == OP_REG) || (opc == OP_IMM) || (opc == OP_LUI) ||
             (opc == OP_LOAD) || (opc == OP_STORE);
   endfunction

   // Reserved funct7 patterns fall back to ADD rather than trapping.
   function automatic alu_ctrl_t alu_decode(input logic [31:0] instr);
      alu_ctrl_t  c;
      logic [2:0] f3;
      logic [6:0] f7;
      f3      = instr[14:12];
      f7      = instr[31:25];
      c.op    = ALU_ADD;
      c.ext   = EXT_ADDI;
      c.src_b = 1'b1;
      case (instr[6:0])
         OP_REG: begin
            c.src_b = 1'b0;
            if (f7 == 7'h00) begin
               case (f3)
                  3'd0: c.op = ALU_ADD;
                  3'd1: c.op = ALU_SLL;
                  3'd2: c.op = ALU_SLT;
                  3'd3: c.op = ALU_SLTU;
                  3'd4: c.op = ALU_XOR;
                  3'd5: c.op = ALU_SRL;
                  3'd6: c.op = ALU_OR;
                  3'd7: c.op = ALU_AND;
               endcase
            end else if (f7 == 7'h20) begin
               if (f3 == 3'd0)      c.op = ALU_SUB;
               else if (f3 == 3'd5) c.op = ALU_SRA;
            end
         end
         OP_IMM: begin
            case (f3)
               3'd0: c.op = ALU_ADD;
               3'd1: begin
                  c.ext = EXT_SLLI;
                  if (f7 == 7'h00) c.op = ALU_SLL;
               end
               3'd2: c.op = ALU_SLT;
               3'd3: c.op = ALU_SLTU;
               3'd4: c.op = ALU_XOR;
               3'd5: begin
                  c.ext = EXT_SLLI;
                  if (f7 == 7'h00)      c.op = ALU_SRL;
                  else if (f7 == 7'h20) c.op = ALU_SRA;
               end
               3'd6: c.op = ALU_OR;
               3'd7: c.op = ALU_AND;
            endcase
         end
         OP_LUI: begin
            c.op  = ALU_BPASS;
            c.ext = EXT_LUI;
         end
         OP_STORE: c.ext = EXT_SW;
         default: ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait-state counter; combinational timeout once MEM_TIMEOUT waits have elapsed and the
// request is still unanswered. A ready in the terminal cycle suppresses the timeout.
module mem_wait_timer #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic req,
   input  logic ready,
   input  logic clear,
   output logic timeout
);

   generate
      if (MEM_TIMEOUT > 0) begin : g_timer
         localparam int CW = $clog2(MEM_TIMEOUT + 1);
         logic [CW-1:0] count;

         always_ff @(posedge clk or negedge reset) begin
            if (!reset)                      count <= '0;
            else if (!req || ready || clear) count <= '0;
            else                             count <= count + 1'b1;
         end

         assign timeout = req && !ready && (count == CW'(MEM_TIMEOUT));
      end else begin : g_no_timer
         assign timeout = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/multicycle_controller.sv
// RV32I multicycle control FSM on one shared memory port: 4 cycles ALU/store, 5 load, +1 per wait.
// Requests hold stable until mem_ready; MULTICYCLE_CONTROLLER_PERF_EN adds cycle/instret counters.
module multicycle_controller
   import cpu_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        run,
   input  logic [31:0] instr,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic        adr_src,
   output logic        ir_write,
   output logic        pc_write,
   output logic        reg_write,
   output logic        alu_src_b,
   output logic        result_src,
   output logic [3:0]  alu_op,
   output logic [2:0]  sign_extend_type,
   output logic        busy,
   output logic        halted,
   output logic [1:0]  fault
`ifdef MULTICYCLE_CONTROLLER_PERF_EN
   ,
   output logic [31:0] cycle_count,
   output logic [31:0] instret_count
`endif
);

   ctrl_state_t state, state_next;
   fault_t      fault_q;
   alu_ctrl_t   ctrl;
   logic        timeout;

   assign ctrl = alu_decode(instr);

   mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
      .clk     (clk),
      .reset   (reset),
      .req     (mem_req),
      .ready   (mem_ready),
      .clear   (state_next != state),
      .timeout (timeout)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:      if (run) state_next = S_FETCH;
         S_FETCH: begin
            if (mem_ready)    state_next = S_DECODE;
            else if (timeout) state_next = S_HALT;
         end
         S_DECODE:    state_next = opcode_legal(instr[6:0]) ? S_EXECUTE : S_HALT;
         S_EXECUTE: begin
            case (instr[6:0])
               OP_LOAD:  state_next = S_MEM_READ;
               OP_STORE: state_next = S_MEM_WRITE;
               default:  state_next = S_ALU_WB;
            endcase
         end
         S_ALU_WB,
         S_MEM_WB:    state_next = run ? S_FETCH : S_IDLE;
         S_MEM_READ: begin
            if (mem_ready)    state_next = S_MEM_WB;
            else if (timeout) state_next = S_HALT;
         end
         S_MEM_WRITE: begin
            if (mem_ready)    state_next = run ? S_FETCH : S_IDLE;
            else if (timeout) state_next = S_HALT;
         end
         S_HALT:      state_next = S_HALT;
         default:     state_next = S_IDLE;
      endcase
   end

   // Decoded ALU controls stay on from EXECUTE until the instruction retires.
   always_comb begin
      mem_req          = 1'b0;
      mem_we           = 1'b0;
      adr_src          = 1'b0;
      ir_write         = 1'b0;
      pc_write         = 1'b0;
      reg_write        = 1'b0;
      alu_src_b        = 1'b0;
      result_src       = 1'b0;
      alu_op           = ALU_ADD;
      sign_extend_type = EXT_ADDI;
      busy             = (state != S_IDLE) && (state != S_HALT);
      halted           = (state == S_HALT);
      if ((state == S_EXECUTE) || (state == S_ALU_WB) || (state == S_MEM_READ) ||
          (state == S_MEM_WB) || (state == S_MEM_WRITE)) begin
         alu_op           = ctrl.op;
         sign_extend_type = ctrl.ext;
         alu_src_b        = ctrl.src_b;
      end
      case (state)
         S_FETCH: begin
            mem_req  = 1'b1;
            ir_write = mem_ready;
            pc_write = mem_ready;
         end
         S_ALU_WB:   reg_write = 1'b1;
         S_MEM_READ: begin
            mem_req = 1'b1;
            adr_src = 1'b1;
         end
         S_MEM_WB: begin
            reg_write  = 1'b1;
            result_src = 1'b1;
         end
         S_MEM_WRITE: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            adr_src = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         fault_q <= FAULT_NONE;
      else if ((state == S_DECODE) && !opcode_legal(instr[6:0]))
         fault_q <= FAULT_ILLEGAL;
      else if (timeout && (state_next == S_HALT))
         fault_q <= FAULT_TIMEOUT;
   end

   assign fault = fault_q;

`ifdef MULTICYCLE_CONTROLLER_PERF_EN
   logic retire;
   assign retire = (state == S_ALU_WB) || (state == S_MEM_WB) ||
                   ((state == S_MEM_WRITE) && mem_ready);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cycle_count   <= '0;
         instret_count <= '0;
      end else begin
         if (busy)   cycle_count   <= cycle_count + 32'd1;
         if (retire) instret_count <= instret_count + 32'd1;
      end
   end
`endif

endmodule
